// File: rtl/hbm_channel_responder.sv
// AXI4 slave subset standing in for an HBM pseudo-channel: word-addressed simple dual-port memory
// serving one write burst and one read burst concurrently.
module hbm_channel_responder #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
   parameter int unsigned C_MEM_DEPTH        = 1024,
   parameter int unsigned C_RD_GAP           = 0
) (
   input  logic                              aclk,
   input  logic                              areset_n,
   input  logic                              s_axi_awvalid,
   output logic                              s_axi_awready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                        s_axi_awlen,
   input  logic                              s_axi_wvalid,
   output logic                              s_axi_wready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                              s_axi_wlast,
   output logic                              s_axi_bvalid,
   input  logic                              s_axi_bready,
   input  logic                              s_axi_arvalid,
   output logic                              s_axi_arready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                        s_axi_arlen,
   output logic                              s_axi_rvalid,
   input  logic                              s_axi_rready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic                              s_axi_rlast,
   output logic                              wlast_err,
   output logic                              busy
);

   localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(C_MEM_DEPTH);
   localparam int unsigned GAP_W  = 4;
   localparam int unsigned REM_W  = 9;
   localparam logic [GAP_W-1:0] GAP_RELOAD = (C_RD_GAP == 0) ? GAP_W'(0) : GAP_W'(C_RD_GAP - 1);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

   logic [C_M_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

   wr_state_e                     w_state_q;
   logic                          awready_q, wready_q, bvalid_q, wlast_err_q;
   logic [IDX_W-1:0]              w_idx_q;
   logic [7:0]                    w_cnt_q;

   rd_state_e                     r_state_q;
   logic                          arready_q, rvalid_q, rlast_q;
   logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
   logic [IDX_W-1:0]              r_idx_q;
   logic [REM_W-1:0]              r_rem_q;
   logic                          m_valid_q, m_last_q;
   logic [C_M_AXI_DATA_WIDTH-1:0] mem_q;
   logic [GAP_W-1:0]              gap_q;

   logic                          w_beat, r_hs, r_load, r_fetch;
   logic                          unused_addr_bits;

   assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

   assign w_beat  = (w_state_q == W_DATA) && s_axi_wvalid && wready_q;
   assign r_hs    = rvalid_q && s_axi_rready;
   // Output register refills on the handshake cycle only when no gap is configured.
   assign r_load  = (r_state_q == R_DATA) && m_valid_q && (gap_q == '0) &&
                    (!rvalid_q || (r_hs && (C_RD_GAP == 0)));
   assign r_fetch = (r_state_q == R_DATA) && (r_rem_q != '0) && (!m_valid_q || r_load);

   // Write burst FSM
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         w_state_q   <= W_IDLE;
         awready_q   <= 1'b1;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         wlast_err_q <= 1'b0;
         w_idx_q     <= '0;
         w_cnt_q     <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (s_axi_awvalid && awready_q) begin
                  w_idx_q   <= s_axi_awaddr[LSB +: IDX_W];
                  w_cnt_q   <= s_axi_awlen;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  w_state_q <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_beat) begin
                  w_idx_q <= w_idx_q + IDX_W'(1);
                  w_cnt_q <= w_cnt_q - 8'd1;
                  if (s_axi_wlast != (w_cnt_q == 8'd0)) wlast_err_q <= 1'b1;
                  if (w_cnt_q == 8'd0) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     w_state_q <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   // Memory: byte-strobed write port, registered read port (read-before-write on collision)
   always_ff @(posedge aclk) begin
      if (w_beat) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) mem[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
         end
      end
      if (r_fetch) mem_q <= mem[r_idx_q];
   end

   // Read burst FSM: fetch stage (mem_q) feeding the output register, acting as the skid slot
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         r_idx_q   <= '0;
         r_rem_q   <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         gap_q     <= '0;
      end else begin
         if (gap_q != '0) gap_q <= gap_q - GAP_W'(1);
         case (r_state_q)
            R_IDLE: begin
               if (s_axi_arvalid && arready_q) begin
                  r_idx_q   <= s_axi_araddr[LSB +: IDX_W];
                  r_rem_q   <= {1'b0, s_axi_arlen} + REM_W'(1);
                  arready_q <= 1'b0;
                  r_state_q <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_fetch) begin
                  r_idx_q   <= r_idx_q + IDX_W'(1);
                  r_rem_q   <= r_rem_q - REM_W'(1);
                  m_valid_q <= 1'b1;
                  m_last_q  <= (r_rem_q == REM_W'(1));
               end else if (r_load) begin
                  m_valid_q <= 1'b0;
               end
               if (r_load) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= mem_q;
                  rlast_q  <= m_last_q;
               end else if (r_hs) begin
                  rvalid_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  if (C_RD_GAP != 0) gap_q <= GAP_RELOAD;
               end
               if (r_hs && rlast_q) begin
                  arready_q <= 1'b1;
                  r_state_q <= R_IDLE;
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rlast   = rlast_q;
   assign wlast_err     = wlast_err_q;
   assign busy          = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);

endmodule

// File: tb/tb_hbm_channel_responder.sv
// Bench for hbm_channel_responder: drives AXI bursts and compares against a flat word-array model.
module tb_hbm_channel_responder;
   localparam int unsigned AW = 64;
   localparam int unsigned DW = 512;
   localparam int unsigned SW = DW / 8;
   localparam int unsigned DEPTH = 1024;

   logic          aclk = 1'b0;
   logic          areset_n = 1'b0;
   logic          s_axi_awvalid, s_axi_awready;
   logic [AW-1:0] s_axi_awaddr;
   logic [7:0]    s_axi_awlen;
   logic          s_axi_wvalid, s_axi_wready;
   logic [DW-1:0] s_axi_wdata;
   logic [SW-1:0] s_axi_wstrb;
   logic          s_axi_wlast;
   logic          s_axi_bvalid, s_axi_bready;
   logic          s_axi_arvalid, s_axi_arready;
   logic [AW-1:0] s_axi_araddr;
   logic [7:0]    s_axi_arlen;
   logic          s_axi_rvalid, s_axi_rready;
   logic [DW-1:0] s_axi_rdata;
   logic          s_axi_rlast;
   logic          wlast_err, busy;

   hbm_channel_responder #(
      .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW), .C_MEM_DEPTH(DEPTH), .C_RD_GAP(0)
   ) dut (
      .aclk(aclk), .areset_n(areset_n),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
      .wlast_err(wlast_err), .busy(busy)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] wdat [256];
   logic [SW-1:0] wstb [256];
   logic [DW-1:0] rdat [256];
   logic          rlst [256];
   int            rcyc [256];
   int            rd_first, rd_nbeats;
   bit            rd_stable;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic do_reset();
      areset_n = 1'b0;
      tick();
      tick();
      areset_n = 1'b1;
      tick();
   endtask

   // Issues one write burst from wdat/wstb and records its effect in ref_mem.
   task automatic axi_write(input logic [AW-1:0] addr, input int len, input int wlast_beat,
                            output int b_lat);
      int n;
      int idx;
      idx = int'((addr / 64) % DEPTH);
      s_axi_awvalid = 1'b1;
      s_axi_awaddr  = addr;
      s_axi_awlen   = 8'(len);
      n = 0;
      while (!s_axi_awready && n < 1000) begin tick(); n++; end
      if (n >= 1000) begin checks++; errors++; $display("FAIL aw_timeout awready never seen"); end
      tick();
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         s_axi_wvalid = 1'b1;
         s_axi_wdata  = wdat[i];
         s_axi_wstrb  = wstb[i];
         s_axi_wlast  = (i == wlast_beat);
         n = 0;
         while (!s_axi_wready && n < 1000) begin tick(); n++; end
         if (n >= 1000) begin checks++; errors++; $display("FAIL w_timeout beat %0d", i); end
         tick();
         for (int b = 0; b < SW; b++)
            if (wstb[i][b]) ref_mem[(idx + i) % DEPTH][b*8 +: 8] = wdat[i][b*8 +: 8];
      end
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
      b_lat = 1;
      while (!s_axi_bvalid && b_lat < 1000) begin tick(); b_lat++; end
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
   endtask

   // Issues one read burst; mode 0 rready=1, mode 1 pattern 1,0,0,1, mode 2 random.
   task automatic axi_read(input logic [AW-1:0] addr, input int len, input int mode);
      int n, c, got;
      bit stalled;
      logic [DW-1:0] pdata;
      logic plast;
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = addr;
      s_axi_arlen   = 8'(len);
      n = 0;
      while (!s_axi_arready && n < 1000) begin tick(); n++; end
      if (n >= 1000) begin checks++; errors++; $display("FAIL ar_timeout arready never seen"); end
      tick();
      s_axi_arvalid = 1'b0;
      c = 0; got = 0; stalled = 0; rd_first = -1; rd_stable = 1;
      pdata = '0; plast = 1'b0;
      while (got <= len && c < 4000) begin
         case (mode)
            0:       s_axi_rready = 1'b1;
            1:       s_axi_rready = ((c % 4) == 0) || ((c % 4) == 3);
            default: s_axi_rready = 1'($urandom_range(0, 1));
         endcase
         if (stalled && (!s_axi_rvalid || s_axi_rdata !== pdata || s_axi_rlast !== plast))
            rd_stable = 0;
         if (s_axi_rvalid) begin
            if (rd_first < 0) rd_first = c;
            if (s_axi_rready) begin
               rdat[got] = s_axi_rdata;
               rlst[got] = s_axi_rlast;
               rcyc[got] = c;
               got++;
            end
         end
         stalled = s_axi_rvalid && !s_axi_rready;
         pdata = s_axi_rdata;
         plast = s_axi_rlast;
         tick();
         c++;
      end
      s_axi_rready = 1'b0;
      rd_nbeats = got;
      if (got <= len) begin checks++; errors++; $display("FAIL r_timeout got %0d beats need %0d", got, len + 1); end
   endtask

   task automatic test_reset();
      logic [7:0] st;
      areset_n = 1'b0;
      tick();
      st = {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
            s_axi_rvalid, s_axi_rlast, wlast_err, busy};
      checks++;
      if (st !== 8'b1100_0000) begin errors++; $display("FAIL reset_flags got %b exp 11000000", st); end
      checks++;
      if (s_axi_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", s_axi_rdata); end
      areset_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || s_axi_awready !== 1'b1) begin
         errors++; $display("FAIL post_reset busy=%b awready=%b exp 0/1", busy, s_axi_awready);
      end
   endtask

   task automatic test_basic();
      int bl;
      for (int i = 0; i < 4; i++) begin wdat[i] = DW'(i); wstb[i] = '1; end
      axi_write(64'h0, 3, 3, bl);
      checks++;
      if (bl != 1) begin errors++; $display("FAIL basic_b_latency got %0d exp 1", bl); end
      checks++;
      if (wlast_err !== 1'b0) begin errors++; $display("FAIL basic_wlast_err got %b exp 0", wlast_err); end
      axi_read(64'h0, 3, 0);
      checks++;
      if (rd_first != 2) begin errors++; $display("FAIL basic_r_latency got %0d exp 2", rd_first); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rdat[i] !== DW'(i) || rlst[i] !== (i == 3)) begin
            errors++; $display("FAIL basic_beat%0d got %h last %b exp %0d last %b", i, rdat[i], rlst[i], i, i == 3);
         end
      end
      checks++;
      if (s_axi_arready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_idle arready=%b busy=%b exp 1/0", s_axi_arready, busy);
      end
   endtask

   task automatic test_wrap();
      int bl;
      logic [DW-1:0] a, b;
      a = rand_word();
      b = rand_word();
      wdat[0] = a; wdat[1] = b; wstb[0] = '1; wstb[1] = '1;
      axi_write(64'hFFC0, 1, 1, bl);
      axi_read(64'hFFC0, 0, 0);
      checks++;
      if (rdat[0] !== a || rlst[0] !== 1'b1) begin errors++; $display("FAIL wrap_1023 got %h exp %h", rdat[0], a); end
      axi_read(64'h0, 0, 0);
      checks++;
      if (rdat[0] !== b || rlst[0] !== 1'b1) begin errors++; $display("FAIL wrap_0 got %h exp %h", rdat[0], b); end
   endtask

   task automatic test_strobe();
      int bl;
      logic [DW-1:0] exp_w;
      wdat[0] = '1; wstb[0] = '1;
      axi_write(64'd5 * 64, 0, 0, bl);
      wdat[0] = '0; wstb[0] = SW'(1);
      axi_write(64'd5 * 64, 0, 0, bl);
      exp_w = '1;
      exp_w[7:0] = 8'h00;
      axi_read(64'd5 * 64, 0, 0);
      checks++;
      if (rdat[0] !== exp_w) begin errors++; $display("FAIL strobe got %h exp %h", rdat[0], exp_w); end
   endtask

   task automatic test_backpressure();
      int bl;
      bit consec;
      for (int i = 0; i < 8; i++) begin wdat[i] = rand_word(); wstb[i] = '1; end
      axi_write(64'd100 * 64, 7, 7, bl);
      axi_read(64'd100 * 64, 7, 1);
      checks++;
      if (rd_stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %b exp 1", rd_stable); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rdat[i] !== ref_mem[100 + i] || rlst[i] !== (i == 7)) begin
            errors++; $display("FAIL bp_beat%0d got %h exp %h", i, rdat[i], ref_mem[100 + i]);
         end
      end
      axi_read(64'd100 * 64, 7, 0);
      consec = 1;
      for (int i = 0; i < 8; i++) if (rcyc[i] != 2 + i) consec = 0;
      checks++;
      if (!consec) begin errors++; $display("FAIL bp_throughput first %0d last %0d exp 2 and 9", rcyc[0], rcyc[7]); end
   endtask

   task automatic test_wlast_err();
      int bl;
      for (int i = 0; i < 4; i++) begin wdat[i] = rand_word(); wstb[i] = '1; end
      axi_write(64'd40 * 64, 3, 1, bl);
      checks++;
      if (bl != 1) begin errors++; $display("FAIL werr_b_latency got %0d exp 1", bl); end
      checks++;
      if (wlast_err !== 1'b1) begin errors++; $display("FAIL werr_set got %b exp 1", wlast_err); end
      axi_read(64'd40 * 64, 3, 0);
      checks++;
      if (rdat[3] !== ref_mem[43]) begin errors++; $display("FAIL werr_beat3 got %h exp %h", rdat[3], ref_mem[43]); end
      wdat[0] = rand_word();
      axi_write(64'd50 * 64, 0, 0, bl);
      repeat (5) tick();
      checks++;
      if (wlast_err !== 1'b1) begin errors++; $display("FAIL werr_sticky got %b exp 1", wlast_err); end
      do_reset();
      checks++;
      if (wlast_err !== 1'b0) begin errors++; $display("FAIL werr_clear got %b exp 0", wlast_err); end
   endtask

   task automatic test_concurrent();
      int bl;
      for (int i = 0; i < 16; i++) begin wdat[i] = rand_word(); wstb[i] = '1; end
      axi_write(64'd300 * 64, 15, 15, bl);
      for (int i = 0; i < 16; i++) wdat[i] = rand_word();
      fork
         axi_write(64'd200 * 64, 15, 15, bl);
         axi_read(64'd300 * 64, 15, 2);
      join
      checks++;
      if (bl != 1 || rd_nbeats != 16) begin errors++; $display("FAIL conc_done b_lat %0d beats %0d exp 1/16", bl, rd_nbeats); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rdat[i] !== ref_mem[300 + i] || rlst[i] !== (i == 15)) begin
            errors++; $display("FAIL conc_rd%0d got %h exp %h", i, rdat[i], ref_mem[300 + i]);
         end
      end
      axi_read(64'd200 * 64, 15, 0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rdat[i] !== ref_mem[200 + i]) begin
            errors++; $display("FAIL conc_wr%0d got %h exp %h", i, rdat[i], ref_mem[200 + i]);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      bit quiet;
      s_axi_arvalid = 1'b1;
      s_axi_araddr  = 64'd300 * 64;
      s_axi_arlen   = 8'd15;
      tick();
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b1;
      repeat (5) tick();
      checks++;
      if (s_axi_rvalid !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL midrd_active rvalid=%b busy=%b exp 1/1", s_axi_rvalid, busy);
      end
      areset_n = 1'b0;
      #1;
      checks++;
      if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL midrd_drop rvalid got %b exp 0", s_axi_rvalid); end
      tick();
      areset_n = 1'b1;
      tick();
      checks++;
      if (s_axi_arready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL midrd_release arready=%b busy=%b exp 1/0", s_axi_arready, busy);
      end
      quiet = 1;
      repeat (6) begin if (s_axi_rvalid) quiet = 0; tick(); end
      checks++;
      if (!quiet) begin errors++; $display("FAIL midrd_no_more_beats rvalid seen after reset"); end
      s_axi_rready = 1'b0;
   endtask

   task automatic test_random();
      int bl, idx, len;
      logic [AW-1:0] addr;
      for (int i = 0; i < 256; i++) begin wdat[i] = rand_word(); wstb[i] = '1; end
      axi_write(64'd400 * 64, 255, 255, bl);
      checks++;
      if (s_axi_awready !== 1'b1) begin errors++; $display("FAIL b2b_awready got %b exp 1", s_axi_awready); end
      for (int t = 0; t < 6; t++) begin
         idx  = 400 + int'($urandom_range(0, 200));
         len  = int'($urandom_range(0, 40));
         addr = AW'(idx) * 64 + AW'($urandom_range(0, 63)) + AW'($urandom_range(0, 3)) * 64'h1_0000;
         for (int i = 0; i <= len; i++) begin wdat[i] = rand_word(); wstb[i] = SW'({$urandom, $urandom}); end
         axi_write(addr, len, len, bl);
         checks++;
         if (s_axi_awready !== 1'b1 || bl != 1) begin
            errors++; $display("FAIL rnd%0d_b awready=%b b_lat=%0d exp 1/1", t, s_axi_awready, bl);
         end
      end
      axi_read(64'd400 * 64, 255, 2);
      for (int i = 0; i < 256; i++) begin
         checks++;
         if (rdat[i] !== ref_mem[400 + i] || rlst[i] !== (i == 255)) begin
            errors++; $display("FAIL rnd_rd%0d got %h exp %h", i, rdat[i], ref_mem[400 + i]);
         end
      end
      checks++;
      if (wlast_err !== 1'b0) begin errors++; $display("FAIL rnd_wlast_err got %b exp 0", wlast_err); end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
      s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
      s_axi_rready = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      test_reset();
      test_basic();
      test_wrap();
      test_strobe();
      test_backpressure();
      test_wlast_err();
      test_concurrent();
      test_reset_mid_read();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hbm_channel_responder.md
Name: hbm_channel_responder

Overview:
- AXI4 slave subset: the responder end of the HBM channel controller's master port (AW/W/B and AR/R with addr and len only).
- Backs accesses with an internal word-addressed memory.
- Serves one write burst and one read burst at a time, independently.
- Used as the simulation/emulation HBM pseudo-channel behind the controller, and as a loopback target in FPGA bring-up.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, byte address width.
- C_M_AXI_DATA_WIDTH, 512, data beat width; power of two, >= 32.
- C_MEM_DEPTH, 1024, memory depth in beats; power of two.
- C_RD_GAP, 0, idle cycles inserted after each R beat handshake, 0..15, for backpressure testing.

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  C_M_AXI_ADDR_WIDTH  burst start byte address
- s_axi_awlen  in  8  beats minus one
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  C_M_AXI_DATA_WIDTH  write beat
- s_axi_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  C_M_AXI_ADDR_WIDTH  read start byte address
- s_axi_arlen  in  8  beats minus one
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  C_M_AXI_DATA_WIDTH  read beat
- s_axi_rlast  out  1  last read beat
- wlast_err  out  1  sticky; wlast disagreed with awlen
- busy  out  1  either FSM not IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs 0 except s_axi_awready=1 and s_axi_arready=1. FSMs go to IDLE, wlast_err=0. Memory contents are not reset.
- Reset mid-burst aborts the burst; no B or further R beats are issued.
- Word index = addr[LSB +: log2(C_MEM_DEPTH)], LSB = log2(C_M_AXI_DATA_WIDTH/8); low byte bits are ignored.
- Each subsequent beat uses index+1 modulo C_MEM_DEPTH (wraps silently; no 4KB check).
- Write FSM:
  - IDLE: awready=1, wready=0. On awvalid&&awready, latch index and count=awlen, go WDATA.
  - WDATA: awready=0, wready=1. On each wvalid, write bytes where wstrb=1 to mem[index]; index++, count--.
  - The beat accepted with count==0 is final. If wlast disagrees with (count==0) on any beat, set wlast_err. The burst still ends on count, not wlast.
  - Go WRESP after the final beat. WRESP: bvalid=1 until bready, then IDLE.
  - B is issued the cycle after the final W handshake.
  - awready=1 in IDLE allows back-to-back AW acceptance the cycle after a B handshake.
- Read FSM:
  - IDLE: arready=1. On arvalid&&arready, latch index and count=arlen, go RDATA.
  - RDATA: arready=0; synchronous memory read; rvalid rises 2 cycles after the AR handshake (1 read + 1 output register).
  - rdata and rlast are held stable while rvalid&&!rready.
  - rlast=1 on the beat with count==0.
  - After each handshake: if C_RD_GAP=0, the next beat is presented the next cycle (full throughput, prefetch/skid register required); else rvalid=0 for C_RD_GAP cycles.
  - After the rlast handshake, return to IDLE; arready=1 the next cycle.
- Read and write FSMs run concurrently on a simple dual-port memory. A read of an address written in the same cycle returns the old data; the written value is visible to reads issued one or more cycles later.
- awlen=0 / arlen=0: single-beat bursts, with wlast/rlast on that beat. awlen=255 is the maximum burst.
- busy = (write FSM != IDLE) || (read FSM != IDLE).

Test Plan:
- Reset, then AW addr=0x0 len=3, four W beats data 0..3 strb all-ones, wlast on beat 3: bvalid one cycle after the last W. AR addr=0x0 len=3 returns 0,1,2,3 with rlast only on beat 3 and rvalid two cycles after AR.
- Wrap: C_MEM_DEPTH=1024, 512-bit data, write addr=0xFFC0 len=1 data A,B. Reading index 1023 returns A; reading index 0 returns B.
- Strobes: write 0xFF..FF to index 5, then write wstrb=0x...0001 data=0: read returns low byte 0x00 and all other bytes 0xFF.
- Backpressure: read len=7, toggle rready 1,0,0,1 pattern; rdata/rlast stay stable while stalled and all 8 beats arrive in order. With C_RD_GAP=0 and rready=1, beats arrive in 8 consecutive cycles.
- Protocol error: awlen=3 with wlast on beat 1: wlast_err=1 and stays 1. B issues after beat 3; reset clears wlast_err.
- Concurrency plus reset: simultaneous len=15 read and write to different indices both complete. Asserting areset_n=0 mid-read drops rvalid immediately, and arready=1, busy=0 after release.
